input_node: RTL and testbench
=============================

INPUT_NODE -- requirements
Module: input_node

Interface
REQ-001 Parameter: DIR, default 4'b1000 (DOWN), one-hot port toward the consuming grid node.
REQ-002 Parameter: DEPTH, default 8, buffer entries, power of two.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 host_valid  in  1  host offers host_data this cycle.
REQ-006 host_data  in  16 signed  raw host value, clamped on entry.
REQ-007 host_ready  out  1  node can accept host_data.
REQ-008 out  out  11 signed  value offered to the grid.
REQ-009 write  out  4  one-hot direction offering out; encoding: 0001 L, 0010 R, 0100 U, 1000 D.
REQ-010 wready  in  4  per-direction consumer read pulse; only the DIR bit is used.
REQ-011 count  out  4  buffered entries, 0..DEPTH, excluding the value held in out.
REQ-012 sent  out  16  values retired to the grid.

Function
REQ-013 host_ready SHALL equal (count != DEPTH), from registered count only.
REQ-014 Accept occurs when host_valid && host_ready at a rising edge; the value SHALL be written at the write pointer, and the pointer SHALL increment modulo DEPTH.
REQ-015 Clamp on accept: host_data > 999 stores 999; host_data < -999 stores -999; otherwise the value is stored unchanged, truncated to 11 bits.
REQ-016 Output FSM SHALL have three states: IDLE, OFFER, GAP.
REQ-017 IDLE: write = 0; if count != 0, the head SHALL load into out, write <= DIR, the read pointer SHALL increment modulo DEPTH, and the FSM SHALL enter OFFER.
REQ-018 OFFER: write holds DIR and out holds stable until (wready & DIR) != 0; at that edge write <= 0, sent <= sent + 1, and the FSM SHALL enter GAP.
REQ-019 GAP: one cycle with write = 0, then IDLE unconditionally.
REQ-020 wready bits other than DIR SHALL be ignored; wready SHALL be ignored in IDLE and GAP.
REQ-021 Latency: an accept at edge N with an empty buffer and FSM in IDLE SHALL raise write after edge N+1.
REQ-022 Minimum spacing between consecutive offers is 3 cycles (OFFER, GAP, IDLE→OFFER).
REQ-023 A simultaneous accept and head-load SHALL leave count unchanged and pointers both advanced.
REQ-024 Full plus head-load in the same cycle: no accept that cycle, since host_ready is low; accept is possible next cycle.
REQ-025 Empty buffer in IDLE: remain IDLE, write = 0, out holds its last value.
REQ-026 Pointers wrap at DEPTH, with no loss or duplication across the wrap.
REQ-027 sent SHALL wrap modulo 2^16.
REQ-028 count SHALL never exceed DEPTH and never underflow.

Reset
REQ-029 On rst_n low, asynchronously: out = 0, write = 0, count = 0, sent = 0, pointers = 0, FSM = IDLE; host_ready SHALL be 1 after release.
REQ-030 Reset mid-OFFER discards the offered value and all buffered values; no write SHALL be asserted until a new accept occurs.

Structure
REQ-031 Shared package tis_pkg SHALL hold: word width 11, TIS_MAX = 999, TIS_MIN = -999, direction constants DIR_L/DIR_R/DIR_U/DIR_D, the clamp function, and the FSM state enum.
REQ-032 Buffer SHALL be one sub-module, tis_fifo (DEPTH x 11, push/pop/count); the FSM, clamp logic and sent counter stay in input_node.

Verification
REQ-033 Reset, push 5, wready[3] held high → out sequence 5 on down port; sent = 1; write pulse pattern OFFER/GAP/IDLE repeated.
REQ-034 Push 1500, -2000, 42 → out values 999, -999, 42 in order.
REQ-035 wready = 4'b0111 held during OFFER → write stays 1000 and sent does not change; then wready = 1000 → retire.
REQ-036 Push 9 values with no wready → host_ready low after 9 accepts (8 in buffer plus 1 in out); count = 8; 10th value held off until one retire.
REQ-037 Stream 20 values 0..19 with random wready → received order 0..19 exactly; sent = 20; pointer wrap exercised.
REQ-038 Assert rst_n low during OFFER with count = 3 → write = 0 and count = 0 immediately; no further offers occur without new pushes.

Source files
------------

// File: rtl/tis_pkg.sv
// Shared word format, port directions, output FSM states and entry clamp for TIS grid nodes.
package tis_pkg;

    localparam int unsigned TIS_W = 11;
    localparam logic signed [TIS_W-1:0] TIS_MAX = 11'sd999;
    localparam logic signed [TIS_W-1:0] TIS_MIN = -11'sd999;

    localparam logic [3:0] DIR_L = 4'b0001;
    localparam logic [3:0] DIR_R = 4'b0010;
    localparam logic [3:0] DIR_U = 4'b0100;
    localparam logic [3:0] DIR_D = 4'b1000;

    typedef enum logic [1:0] {
        StIdle,
        StOffer,
        StGap
    } tis_state_e;

    // Saturate a 16-bit host value into the node's -999..999 range.
    function automatic logic signed [TIS_W-1:0] tis_clamp(input logic signed [15:0] v);
        logic signed [15:0] hi;
        logic signed [15:0] lo;
        hi = {{(16 - TIS_W){TIS_MAX[TIS_W-1]}}, TIS_MAX};
        lo = {{(16 - TIS_W){TIS_MIN[TIS_W-1]}}, TIS_MIN};
        if (v > hi) begin
            tis_clamp = TIS_MAX;
        end else if (v < lo) begin
            tis_clamp = TIS_MIN;
        end else begin
            tis_clamp = v[TIS_W-1:0];
        end
    endfunction

endpackage

// File: rtl/tis_fifo.sv
// Circular word buffer feeding the input node; head is read combinationally at the read pointer.
module tis_fifo
    import tis_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [TIS_W-1:0] data_i,
    input  logic             pop_i,
    output logic [TIS_W-1:0] data_o,
    output logic [3:0]       count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [TIS_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]       count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/input_node.sv
// Host-facing grid node: clamps host words into a buffer and offers them one at a time on port DIR.
module input_node
    import tis_pkg::*;
#(
    parameter logic [3:0]  DIR   = DIR_D,
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    host_valid,
    input  logic signed [15:0]      host_data,
    output logic                    host_ready,
    output logic signed [TIS_W-1:0] out,
    output logic [3:0]              write,
    input  logic [3:0]              wready,
    output logic [3:0]              count,
    output logic [15:0]             sent
);

    localparam logic [3:0] DepthCnt = 4'(DEPTH);

    if (!((DIR == DIR_L) || (DIR == DIR_R) || (DIR == DIR_U) || (DIR == DIR_D))) begin : g_bad_dir
        $error("input_node: DIR must be one-hot");
    end

    tis_state_e              state_q;
    logic signed [TIS_W-1:0] out_q;
    logic [3:0]              write_q;
    logic [15:0]             sent_q;

    logic [TIS_W-1:0] head;
    logic [3:0]       fifo_count;
    logic             accept;
    logic             load;

    assign host_ready = (fifo_count != DepthCnt);
    assign accept     = host_valid && host_ready;
    assign load       = (state_q == StIdle) && (fifo_count != 4'd0);

    tis_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (accept),
        .data_i  (tis_clamp(host_data)),
        .pop_i   (load),
        .data_o  (head),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            out_q   <= '0;
            write_q <= '0;
            sent_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    write_q <= '0;
                    if (load) begin
                        out_q   <= $signed(head);
                        write_q <= DIR;
                        state_q <= StOffer;
                    end
                end
                StOffer: begin
                    // Only the consumer on our own port may retire the word.
                    if ((wready & DIR) != 4'd0) begin
                        write_q <= '0;
                        sent_q  <= sent_q + 16'd1;
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    write_q <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    write_q <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign out   = out_q;
    assign write = write_q;
    assign count = fifo_count;
    assign sent  = sent_q;

endmodule

// File: tb/tb_input_node.sv
// Directed bench for input_node: clamp vector table plus offer/backpressure/wrap/reset sequences.
module tb_input_node;

    localparam logic [3:0] DIR = 4'b1000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               host_valid;
    logic signed [15:0] host_data;
    logic               host_ready;
    logic signed [10:0] out;
    logic [3:0]         write;
    logic [3:0]         wready;
    logic [3:0]         count;
    logic [15:0]        sent;

    int errors = 0;
    int checks = 0;
    int sent_exp = 0;

    typedef struct {
        logic signed [15:0] din;
        int                 exp;
    } vec_t;

    vec_t vecs[12];
    int   rx[$];

    input_node #(
        .DIR   (DIR),
        .DEPTH (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_valid (host_valid),
        .host_data  (host_data),
        .host_ready (host_ready),
        .out        (out),
        .write      (write),
        .wready     (wready),
        .count      (count),
        .sent       (sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_offer();
        int n = 0;
        while (write !== DIR && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (write !== DIR) chk("offer_timeout", int'(write), int'(DIR));
    endtask

    task automatic retire(input int exp_out);
        wait_offer();
        chk("retire_out", int'(out), exp_out);
        wready = DIR;
        @(negedge clk);
        wready = 4'd0;
        sent_exp++;
        chk("retire_sent", int'(sent), sent_exp);
        chk("retire_write", int'(write), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wexp[10];
        int oexp[3];
        int oi;
        int n;

        vecs[0]  = '{16'sd1500, 999};
        vecs[1]  = '{-16'sd2000, -999};
        vecs[2]  = '{16'sd42, 42};
        vecs[3]  = '{16'sd999, 999};
        vecs[4]  = '{16'sd1000, 999};
        vecs[5]  = '{-16'sd999, -999};
        vecs[6]  = '{-16'sd1000, -999};
        vecs[7]  = '{16'sd0, 0};
        vecs[8]  = '{-16'sd1, -1};
        vecs[9]  = '{16'sd32767, 999};
        vecs[10] = '{-16'sd32768, -999};
        vecs[11] = '{16'sd998, 998};

        rst_n = 1'b0;
        host_valid = 1'b0;
        host_data = '0;
        wready = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_write", int'(write), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_sent", int'(sent), 0);
        chk("rst_out", int'(out), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_host_ready", int'(host_ready), 1);
        chk("idle_write", int'(write), 0);

        // Clamp table, one word at a time through an idle node.
        foreach (vecs[i]) begin
            host_valid = 1'b1;
            host_data = vecs[i].din;
            @(negedge clk);
            host_valid = 1'b0;
            chk("lat_write_n", int'(write), 0);
            chk("lat_count_n", int'(count), 1);
            @(negedge clk);
            chk("lat_write_n1", int'(write), int'(DIR));
            chk("clamp_out", int'(out), vecs[i].exp);
            chk("clamp_count", int'(count), 0);
            wready = DIR;
            @(negedge clk);
            wready = 4'd0;
            sent_exp++;
            chk("clamp_write_gap", int'(write), 0);
            chk("clamp_sent", int'(sent), sent_exp);
            @(negedge clk);
        end

        // Idle with empty buffer keeps last value and no write.
        repeat (3) @(negedge clk);
        chk("empty_write", int'(write), 0);
        chk("empty_out", int'(out), 998);

        // Back-to-back words with wready held: OFFER/GAP/IDLE cadence.
        wexp = '{0, 8, 0, 0, 8, 0, 0, 8, 0, 0};
        oexp = '{5, 6, 7};
        oi = 0;
        wready = DIR;
        host_valid = 1'b1;
        host_data = 16'sd5;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) host_data = 16'sd6;
            if (k == 1) host_data = 16'sd7;
            if (k == 2) host_valid = 1'b0;
            chk("cadence_write", int'(write), wexp[k]);
            if (wexp[k] != 0 && oi < 3) begin
                chk("cadence_out", int'(out), oexp[oi]);
                oi++;
            end
        end
        wready = 4'd0;
        sent_exp += 3;
        chk("cadence_sent", int'(sent), sent_exp);

        // Non-DIR wready bits must not retire.
        host_valid = 1'b1;
        host_data = 16'sd77;
        @(negedge clk);
        host_valid = 1'b0;
        wait_offer();
        wready = 4'b0111;
        repeat (3) begin
            @(negedge clk);
            chk("other_bits_write", int'(write), int'(DIR));
            chk("other_bits_sent", int'(sent), sent_exp);
            chk("other_bits_out", int'(out), 77);
        end
        wready = DIR;
        @(negedge clk);
        wready = 4'd0;
        sent_exp++;
        chk("other_bits_retire_write", int'(write), 0);
        chk("other_bits_retire_sent", int'(sent), sent_exp);
        @(negedge clk);

        // Fill: nine accepts (one in out, eight buffered), tenth held off.
        host_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            host_data = 16'(100 + i);
            @(negedge clk);
        end
        host_data = 16'sd109;
        chk("full_host_ready", int'(host_ready), 0);
        chk("full_count", int'(count), 8);
        chk("full_write", int'(write), int'(DIR));
        chk("full_out", int'(out), 100);
        repeat (2) begin
            @(negedge clk);
            chk("full_hold_count", int'(count), 8);
        end
        wready = DIR;
        @(negedge clk);
        wready = 4'd0;
        sent_exp++;
        chk("full_retire_sent", int'(sent), sent_exp);
        chk("full_gap_count", int'(count), 8);
        n = 0;
        while (!host_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("full_reopen", int'(host_ready), 1);
        chk("full_reopen_count", int'(count), 7);
        @(negedge clk);
        host_valid = 1'b0;
        chk("full_refill_count", int'(count), 8);
        for (int v = 101; v <= 109; v++) retire(v);
        @(negedge clk);
        chk("drain_count", int'(count), 0);

        // Stream 0..19 with random wready, including stray non-DIR bits.
        fork
            begin
                int i = 0;
                int cyc = 0;
                while (i < 20 && cyc < 2000) begin
                    if (host_ready) begin
                        host_valid = 1'b1;
                        host_data = 16'(i);
                        i++;
                    end else begin
                        host_valid = 1'b0;
                    end
                    @(negedge clk);
                    cyc++;
                end
                host_valid = 1'b0;
            end
            begin
                int cyc = 0;
                while (rx.size() < 20 && cyc < 2000) begin
                    wready = 4'($urandom_range(0, 15));
                    if (write == DIR && wready[3]) rx.push_back(int'(out));
                    @(negedge clk);
                    cyc++;
                end
                wready = 4'd0;
            end
        join
        chk("stream_size", rx.size(), 20);
        foreach (rx[i]) chk("stream_order", rx[i], i);
        sent_exp += 20;
        chk("stream_sent", int'(sent), sent_exp);
        repeat (2) @(negedge clk);

        // Reset while offering with three words buffered.
        host_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            host_data = 16'(11 + i);
            @(negedge clk);
        end
        host_valid = 1'b0;
        chk("pre_rst_count", int'(count), 3);
        chk("pre_rst_write", int'(write), int'(DIR));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_write", int'(write), 0);
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_out", int'(out), 0);
        chk("async_rst_sent", int'(sent), 0);
        sent_exp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_write", int'(write), 0);
        end
        host_valid = 1'b1;
        host_data = 16'sd55;
        @(negedge clk);
        host_valid = 1'b0;
        retire(55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
